cr16_datapath_controller: RTL and testbench

Instruction sequencer that sits in front of cr16_datapath and drives all of its control inputs: ALU opcode, register A/B selects, immediate and immediate-select, and the one-hot register write enable. It accepts 16-bit instruction words over a valid/ready handshake. An optional second word carries a 16-bit immediate. Each instruction runs through a fixed fetch/execute/writeback sequence, and the controller latches the datapath result and status flags for the requester.

---
 rtl/cr16_datapath_controller.sv | 117 +++++++++++
 tb/tb_cr16_datapath_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cr16_datapath_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cr16_datapath_controller                                                 |
// | Sequences 16-bit instructions into cr16_datapath control inputs.         |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module cr16_datapath_controller #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 16
) (
  input  logic                  I_CLK,
  input  logic                  I_NRESET,
  input  logic                  I_ENABLE,
  input  logic [DATA_WIDTH-1:0] I_INSTR,
  input  logic                  I_INSTR_VALID,
  output logic                  O_INSTR_READY,
  input  logic [DATA_WIDTH-1:0] I_DP_RESULT_BUS,
  input  logic [4:0]            I_DP_STATUS_FLAGS,
  output logic [3:0]            O_DP_OPCODE,
  output logic [3:0]            O_DP_REG_A_SELECT,
  output logic [3:0]            O_DP_REG_B_SELECT,
  output logic [DATA_WIDTH-1:0] O_DP_IMMEDIATE,
  output logic                  O_DP_IMMEDIATE_SELECT,
  output logic [NUM_REGS-1:0]   O_DP_REG_WRITE_ENABLE,
  output logic [DATA_WIDTH-1:0] O_RESULT,
  output logic [4:0]            O_FLAGS,
  output logic                  O_DONE,
  output logic                  O_ERROR,
  output logic [DATA_WIDTH-1:0] O_INSTR_COUNT
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH_IMM = 3'd1,
    S_EXEC      = 3'd2,
    S_WB        = 3'd3,
    S_DONE      = 3'd4,
    S_ERR       = 3'd5
  } state_t;

  state_t                r_state;
  logic [3:0]            r_op;
  logic [3:0]            r_rdest;
  logic [3:0]            r_rsrc;
  logic                  r_imm_en;
  logic                  r_nowb;
  logic [DATA_WIDTH-1:0] r_imm;
  logic [DATA_WIDTH-1:0] r_result;
  logic [4:0]            r_flags;
  logic [DATA_WIDTH-1:0] r_count;
  logic                  w_write;

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_rdest  <= '0;
      r_rsrc   <= '0;
      r_imm_en <= 1'b0;
      r_nowb   <= 1'b0;
      r_imm    <= '0;
      r_result <= '0;
      r_flags  <= '0;
      r_count  <= '0;
    end else if (I_ENABLE) begin
      case (r_state)
        S_IDLE: begin
          if (I_INSTR_VALID) begin
            r_op     <= I_INSTR[15:12];
            r_rdest  <= I_INSTR[11:8];
            r_rsrc   <= I_INSTR[7:4];
            r_imm_en <= I_INSTR[0];
            r_nowb   <= I_INSTR[1];
            if (I_INSTR[3:2] != 2'b00) r_state <= S_ERR;
            else if (I_INSTR[0])       r_state <= S_FETCH_IMM;
            else                       r_state <= S_EXEC;
          end
        end
        S_FETCH_IMM: begin
          if (I_INSTR_VALID) begin
            r_imm   <= I_INSTR;
            r_state <= S_EXEC;
          end
        end
        // EXEC is the datapath settle cycle; nothing is written yet.
        S_EXEC: r_state <= S_WB;
        S_WB: begin
          r_result <= I_DP_RESULT_BUS;
          r_flags  <= I_DP_STATUS_FLAGS;
          r_count  <= r_count + 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Gating with I_ENABLE ties the write to the single enabled WB edge.
  assign w_write = I_ENABLE && (r_state == S_WB) && !r_nowb;

  assign O_DP_REG_WRITE_ENABLE = w_write ? (NUM_REGS'(1) << r_rdest) : '0;
  assign O_INSTR_READY         = I_ENABLE && ((r_state == S_IDLE) || (r_state == S_FETCH_IMM));
  assign O_DP_OPCODE           = r_op;
  assign O_DP_REG_A_SELECT     = r_rdest;
  assign O_DP_REG_B_SELECT     = r_rsrc;
  assign O_DP_IMMEDIATE        = r_imm;
  assign O_DP_IMMEDIATE_SELECT = r_imm_en;
  assign O_RESULT              = r_result;
  assign O_FLAGS               = r_flags;
  assign O_DONE                = (r_state == S_DONE);
  assign O_ERROR               = (r_state == S_ERR);
  assign O_INSTR_COUNT         = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cr16_datapath_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cr16_datapath_controller                                              |
// | Directed bench for the instruction sequencer.                            |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_cr16_datapath_controller;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] dp_result;
  logic [4:0]  dp_flags;
  logic [3:0]  dp_opcode;
  logic [3:0]  dp_a_sel;
  logic [3:0]  dp_b_sel;
  logic [15:0] dp_imm;
  logic        dp_imm_sel;
  logic [15:0] dp_we;
  logic [15:0] result;
  logic [4:0]  flags;
  logic        done;
  logic        error;
  logic [15:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  cr16_datapath_controller #(.DATA_WIDTH(16), .NUM_REGS(16)) dut (
    .I_CLK                 (clk),
    .I_NRESET              (rst_n),
    .I_ENABLE              (enable),
    .I_INSTR               (instr),
    .I_INSTR_VALID         (instr_valid),
    .O_INSTR_READY         (instr_ready),
    .I_DP_RESULT_BUS       (dp_result),
    .I_DP_STATUS_FLAGS     (dp_flags),
    .O_DP_OPCODE           (dp_opcode),
    .O_DP_REG_A_SELECT     (dp_a_sel),
    .O_DP_REG_B_SELECT     (dp_b_sel),
    .O_DP_IMMEDIATE        (dp_imm),
    .O_DP_IMMEDIATE_SELECT (dp_imm_sel),
    .O_DP_REG_WRITE_ENABLE (dp_we),
    .O_RESULT              (result),
    .O_FLAGS               (flags),
    .O_DONE                (done),
    .O_ERROR               (error),
    .O_INSTR_COUNT         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; instr = '0; instr_valid = 1'b0;
    dp_result = '0; dp_flags = '0;
    #1;
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_we", {16'd0, dp_we}, 32'd0);
    check("rst_count", {16'd0, count}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_done_err", {30'd0, done, error}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 0x0120: r1 <- op0(r1, r2); datapath model holds r1=5, r2=3 -> 8
    instr = 16'h0120; instr_valid = 1'b1;
    check("t1_ready", {31'd0, instr_ready}, 32'd1);
    tick(); instr_valid = 1'b0;
    check("t1_exec_sel", {20'd0, dp_opcode, dp_a_sel, dp_b_sel}, 32'h012);
    check("t1_exec_we", {16'd0, dp_we}, 32'd0);
    check("t1_exec_immsel", {31'd0, dp_imm_sel}, 32'd0);
    dp_result = 16'd8; dp_flags = 5'h01;
    tick();
    check("t1_wb_we", {16'd0, dp_we}, 32'h0002);
    tick();
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_done_we", {16'd0, dp_we}, 32'd0);
    check("t1_result", {16'd0, result}, 32'd8);
    check("t1_count", {16'd0, count}, 32'd1);
    check("t1_done_ready", {31'd0, instr_ready}, 32'd0);
    tick();
    check("t1_idle", {30'd0, done, instr_ready}, 32'd1);

    // 0x0301 + immediate 0xFFFF after a 3-cycle valid gap
    instr = 16'h0301; instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_gap_ready", {31'd0, instr_ready}, 32'd1);
      check("t2_gap_we", {16'd0, dp_we}, 32'd0);
      tick();
    end
    instr = 16'hFFFF; instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    check("t2_exec_imm", {15'd0, dp_imm_sel, dp_imm}, 32'h1FFFF);
    check("t2_exec_we", {16'd0, dp_we}, 32'd0);
    dp_result = 16'h1234; dp_flags = 5'h03;
    tick();
    check("t2_wb_imm", {15'd0, dp_imm_sel, dp_imm}, 32'h1FFFF);
    check("t2_wb_we", {16'd0, dp_we}, 32'h0008);
    tick();
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_result", {16'd0, result}, 32'h1234);
    check("t2_count", {16'd0, count}, 32'd2);
    tick();

    // 0x0014: reserved CTRL bit -> error pulse, nothing retires
    instr = 16'h0014; instr_valid = 1'b1; dp_flags = 5'h1F; dp_result = 16'hDEAD;
    tick(); instr_valid = 1'b0;
    check("t3_error", {30'd0, error, done}, 32'd2);
    check("t3_we", {16'd0, dp_we}, 32'd0);
    check("t3_count", {16'd0, count}, 32'd2);
    check("t3_flags", {27'd0, flags}, 32'h03);
    tick();
    check("t3_error_end", {30'd0, error, instr_ready}, 32'd1);
    check("t3_result_hold", {16'd0, result}, 32'h1234);

    // 0x4562: NOWB, flags still captured
    instr = 16'h4562; instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    check("t4_exec_sel", {20'd0, dp_opcode, dp_a_sel, dp_b_sel}, 32'h456);
    check("t4_exec_we", {16'd0, dp_we}, 32'd0);
    dp_result = 16'h5555; dp_flags = 5'h10;
    tick();
    check("t4_wb_we", {16'd0, dp_we}, 32'd0);
    tick();
    check("t4_done", {31'd0, done}, 32'd1);
    check("t4_flags", {27'd0, flags}, 32'h10);
    check("t4_count", {16'd0, count}, 32'd3);
    tick();

    // 0x0730 with a 4-cycle stall in WB
    instr = 16'h0730; instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    tick();
    check("t5_wb_we", {16'd0, dp_we}, 32'h0080);
    enable = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      check("t5_stall_we", {16'd0, dp_we}, 32'd0);
      check("t5_stall_ready", {30'd0, instr_ready, done}, 32'd0);
      tick();
    end
    check("t5_stall_count", {16'd0, count}, 32'd3);
    enable = 1'b1; #1;
    check("t5_resume_we", {16'd0, dp_we}, 32'h0080);
    dp_result = 16'h0777;
    tick();
    check("t5_done", {15'd0, done, dp_we}, 32'h10000);
    check("t5_count", {16'd0, count}, 32'd4);
    check("t5_result", {16'd0, result}, 32'h0777);
    tick();
    check("t5_single_done", {30'd0, done, instr_ready}, 32'd1);
    check("t5_count_hold", {16'd0, count}, 32'd4);

    // 0x0F01 + 0x00AA, reset asserted mid-EXEC
    instr = 16'h0F01; instr_valid = 1'b1;
    tick();
    instr = 16'h00AA;
    tick(); instr_valid = 1'b0;
    check("t6_exec_imm", {15'd0, dp_imm_sel, dp_imm}, 32'h100AA);
    #2 rst_n = 1'b0; #1;
    check("t6_rst_we", {16'd0, dp_we}, 32'd0);
    check("t6_rst_drives", {15'd0, dp_imm_sel, dp_opcode, dp_a_sel, dp_b_sel}, 32'd0);
    check("t6_rst_imm", {16'd0, dp_imm}, 32'd0);
    check("t6_rst_status", {15'd0, done, error, flags, count[8:0]}, 32'd0);
    check("t6_rst_result", {16'd0, result, count}, 32'd0);
    check("t6_rst_ready", {31'd0, instr_ready}, 32'd1);
    tick();
    check("t6_rst_hold_we", {16'd0, dp_we}, 32'd0);
    rst_n = 1'b1;
    tick();
    instr = 16'h0120; instr_valid = 1'b1; dp_result = 16'd8; dp_flags = 5'h01;
    tick(); instr_valid = 1'b0;
    tick();
    check("t6_post_wb_we", {16'd0, dp_we}, 32'h0002);
    tick();
    check("t6_post_done", {15'd0, done, count}, 32'h10001);
    tick();

    // Counter wrap from 0xFFFF
    force dut.r_count = 16'hFFFF;
    #1;
    release dut.r_count;
    #1;
    instr = 16'h0230; instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    tick();
    check("t7_wb_we", {16'd0, dp_we}, 32'h0004);
    tick();
    check("t7_wrap", {15'd0, done, count}, 32'h10000);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
